// File: rtl/led_pattern_mux.sv
// rtl/led_pattern_mux.sv - registered LED pattern selector with blink/chase timers
// Mode-entry restarts the relevant timer; freeze holds every register.
module led_pattern_mux #(
  parameter int                 N_LEDS        = 7,
  parameter int                 BLINK_DIV     = 25_000_000,
  parameter int                 CHASE_DIV     = 5_000_000,
  parameter logic [N_LEDS-1:0]  RESET_PATTERN = 7'b1111011
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LEDS-1:0] score,
  input  logic [2:0]        leds_ctrl,
  input  logic              freeze,
  output logic [N_LEDS-1:0] leds_out
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam int CW = $clog2(CHASE_DIV);
  localparam int PW = $clog2(N_LEDS);

  localparam logic [2:0] M_ALL_OFF = 3'd0;
  localparam logic [2:0] M_ALL_ON  = 3'd1;
  localparam logic [2:0] M_RESET   = 3'd2;
  localparam logic [2:0] M_SCORE   = 3'd3;
  localparam logic [2:0] M_BLINK   = 3'd4;
  localparam logic [2:0] M_ALT     = 3'd5;
  localparam logic [2:0] M_CHASE   = 3'd6;
  localparam logic [2:0] M_BAR     = 3'd7;

  logic [BW-1:0]     r_blink_cnt;
  logic              r_phase;
  logic [CW-1:0]     r_chase_cnt;
  logic [PW-1:0]     r_pos;
  logic [2:0]        r_ctrl_q;
  logic [N_LEDS-1:0] r_leds;

  logic              w_entry;
  logic [BW-1:0]     w_blink_cnt_nxt;
  logic              w_phase_nxt;
  logic [CW-1:0]     w_chase_cnt_nxt;
  logic [PW-1:0]     w_pos_nxt;
  logic [N_LEDS-1:0] w_bar;
  logic [N_LEDS-1:0] w_leds_nxt;

  assign w_entry = (leds_ctrl != r_ctrl_q);

  // Bar bit i is lit when score > i; saturates naturally once score >= N_LEDS.
  for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_bar
    assign w_bar[gi] = (score > N_LEDS'(gi));
  end

  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt + BW'(1);
    w_phase_nxt     = r_phase;
    if (w_entry && (leds_ctrl == M_BLINK || leds_ctrl == M_ALT)) begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = 1'b1;
    end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
      w_blink_cnt_nxt = '0;
      w_phase_nxt     = ~r_phase;
    end
  end

  always_comb begin
    w_chase_cnt_nxt = r_chase_cnt + CW'(1);
    w_pos_nxt       = r_pos;
    if (w_entry && leds_ctrl == M_CHASE) begin
      w_chase_cnt_nxt = '0;
      w_pos_nxt       = '0;
    end else if (r_chase_cnt == CW'(CHASE_DIV - 1)) begin
      w_chase_cnt_nxt = '0;
      w_pos_nxt       = (r_pos == PW'(N_LEDS - 1)) ? '0 : r_pos + PW'(1);
    end
  end

  // Output uses next-state timer values so an entry edge already shows the restarted pattern.
  always_comb begin
    w_leds_nxt = '0;
    case (leds_ctrl)
      M_ALL_OFF: w_leds_nxt = '0;
      M_ALL_ON:  w_leds_nxt = '1;
      M_RESET:   w_leds_nxt = RESET_PATTERN;
      M_SCORE:   w_leds_nxt = score;
      M_BLINK:   w_leds_nxt = w_phase_nxt ? score : '0;
      M_ALT:     w_leds_nxt = w_phase_nxt ? score : ~score;
      M_CHASE:   w_leds_nxt = N_LEDS'(1) << w_pos_nxt;
      M_BAR:     w_leds_nxt = w_bar;
      default:   w_leds_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
      r_chase_cnt <= '0;
      r_pos       <= '0;
      r_ctrl_q    <= '0;
      r_leds      <= '0;
    end else if (!freeze) begin
      r_blink_cnt <= w_blink_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_chase_cnt <= w_chase_cnt_nxt;
      r_pos       <= w_pos_nxt;
      r_ctrl_q    <= leds_ctrl;
      r_leds      <= w_leds_nxt;
    end
  end

  assign leds_out = r_leds;

endmodule
